// File: rtl/riscv_elastic_pipe_pkg.sv
// Shared configuration for the elastic pipeline: default payload width and
// stage-count limits used by the core's stage-to-stage transport.
package riscv_elastic_pipe_pkg;

    localparam int unsigned XLEN                  = 32;
    localparam int unsigned RISCV_PIPE_STAGES     = 5;
    localparam int unsigned RISCV_PIPE_MAX_STAGES = 16;

endpackage

// File: rtl/riscv_elastic_stage.sv
// One elastic pipeline stage: valid/data register plus its local move and
// ready terms. Ready is combinational from the downstream ready.
module riscv_elastic_stage
    import riscv_elastic_pipe_pkg::*;
#(
    parameter int unsigned DW = XLEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          dn_rdy,
    output logic          v,
    output logic [DW-1:0] d,
    output logic          move,
    output logic          rdy,
    output logic          v_next
);

    always_comb begin
        move = v & ~stall & ~flush & dn_rdy;
        // A flushed stage swallows whatever the upstream stage hands it.
        rdy  = flush | (~stall & (~v | move));
    end

    always_comb begin
        v_next = v;
        if (flush) begin
            v_next = 1'b0;
        end else if (load) begin
            v_next = 1'b1;
        end else if (move) begin
            v_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_next;
            if (load && !flush) begin
                d <= load_data;
            end
        end
    end

endmodule

// File: rtl/riscv_elastic_pipe.sv
// Parametrised elastic pipeline of N_STG riscv_elastic_stage instances with
// per-stage stall/flush, bubble collapsing and a registered occupancy count.
module riscv_elastic_pipe
    import riscv_elastic_pipe_pkg::*;
#(
    parameter int unsigned N_STG = RISCV_PIPE_STAGES,
    parameter int unsigned DW    = XLEN
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DW-1:0]              i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DW-1:0]              o_out_data,
    input  logic [N_STG-1:0]           i_stall,
    input  logic [N_STG-1:0]           i_flush,
    output logic [N_STG-1:0]           o_stg_valid,
    output logic [N_STG*DW-1:0]        o_stg_data,
    output logic [$clog2(N_STG+1)-1:0] o_occupancy
);

    localparam int unsigned OW = $clog2(N_STG + 1);

    if (N_STG < 1 || N_STG > RISCV_PIPE_MAX_STAGES) begin : g_bad_n_stg
        $error("riscv_elastic_pipe: N_STG out of range");
    end

    logic [N_STG-1:0] v;
    logic [N_STG-1:0] v_next;
    logic [N_STG-1:0] move;
    logic [N_STG-1:0] rdy;
    logic [N_STG-1:0] load;
    logic [N_STG-1:0] dn_rdy;
    logic [DW-1:0]    d    [N_STG];
    logic [DW-1:0]    up_d [N_STG];
    logic [OW-1:0]    cnt;

    for (genvar k = 0; k < N_STG; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign load[k] = i_in_valid & rdy[k];
            assign up_d[k] = i_in_data;
        end else begin : g_body
            assign load[k] = move[k-1];
            assign up_d[k] = d[k-1];
        end

        if (k == N_STG - 1) begin : g_tail
            assign dn_rdy[k] = i_out_ready;
        end else begin : g_link
            assign dn_rdy[k] = rdy[k+1];
        end

        riscv_elastic_stage #(
            .DW(DW)
        ) u_stage (
            .clk      (i_clk),
            .rst      (i_rst),
            .stall    (i_stall[k]),
            .flush    (i_flush[k]),
            .load     (load[k]),
            .load_data(up_d[k]),
            .dn_rdy   (dn_rdy[k]),
            .v        (v[k]),
            .d        (d[k]),
            .move     (move[k]),
            .rdy      (rdy[k]),
            .v_next   (v_next[k])
        );

        assign o_stg_data[k*DW +: DW] = d[k];
    end

    // Counting next-state valids keeps the registered count aligned with v.
    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < N_STG; k++) begin
            cnt = cnt + OW'(v_next[k]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_occupancy <= '0;
        end else begin
            o_occupancy <= cnt;
        end
    end

    assign o_in_ready  = rdy[0] & ~i_rst;
    assign o_out_valid = v[N_STG-1] & ~i_stall[N_STG-1] & ~i_flush[N_STG-1];
    assign o_out_data  = d[N_STG-1];
    assign o_stg_valid = v;

endmodule

// File: tb/tb_riscv_elastic_pipe.sv
// Self-checking bench for riscv_elastic_pipe: directed scenarios plus random
// traffic, checked against an item-movement model of the pipeline slots.
module tb_riscv_elastic_pipe;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int OW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [N-1:0]      stall;
    logic [N-1:0]      flush;
    logic [N-1:0]      stg_valid;
    logic [N*DW-1:0]   stg_data;
    logic [OW-1:0]     occupancy;

    always #5 clk = ~clk;

    riscv_elastic_pipe #(
        .N_STG(N),
        .DW   (DW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .i_stall    (stall),
        .i_flush    (flush),
        .o_stg_valid(stg_valid),
        .o_stg_data (stg_data),
        .o_occupancy(occupancy)
    );

    int checks   = 0;
    int failures = 0;

    // Model: slot contents of each stage, and the slots after the next edge.
    bit            mv [N];
    logic [DW-1:0] md [N];
    bit            nv [N];
    logic [DW-1:0] nd [N];
    bit            e_in_ready;
    bit            e_out_valid;
    bit            e_accept;

    logic [DW-1:0] inq [$];
    logic [DW-1:0] outq [$];
    int            cyc;
    int            acc_cyc;
    int            out_cyc;
    int            peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
    endtask

    // Walk the slots from the sink back to the source, moving items forward
    // wherever there is room; a flushed slot destroys its item and anything
    // sent into it, an empty unstalled slot always has room.
    task automatic model_plan();
        bit room;
        room = out_ready;
        for (int k = 0; k < N; k++) begin
            nv[k] = mv[k];
            nd[k] = md[k];
        end
        e_out_valid = mv[N-1] && !stall[N-1] && !flush[N-1];
        for (int k = N - 1; k >= 0; k--) begin
            if (flush[k]) begin
                nv[k] = 1'b0;
                room  = 1'b1;
            end else if (stall[k]) begin
                room = 1'b0;
            end else if (!mv[k]) begin
                room = 1'b1;
            end else if (room) begin
                nv[k] = 1'b0;
                if (k < N - 1 && !flush[k+1]) begin
                    nv[k+1] = 1'b1;
                    nd[k+1] = md[k];
                end
                room = 1'b1;
            end else begin
                room = 1'b0;
            end
        end
        e_in_ready = room && !rst;
        e_accept   = in_valid && room && !rst;
        if (e_accept && !flush[0]) begin
            nv[0] = 1'b1;
            nd[0] = in_data;
        end
    endtask

    task automatic check_state();
        int cnt;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("stg_valid[%0d]", k), 32'(stg_valid[k]), 32'(mv[k]));
            chk($sformatf("stg_data[%0d]", k), stg_data[k*DW +: DW], md[k]);
            cnt += int'(mv[k]);
        end
        chk("occupancy", 32'(occupancy), cnt);
        chk("out_data", out_data, md[N-1]);
    endtask

    task automatic reset_checks();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stg_valid", 32'(stg_valid), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_stg_data[%0d]", k), stg_data[k*DW +: DW], 0);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        model_plan();
        check_state();
        chk("in_ready", 32'(in_ready), 32'(e_in_ready));
        chk("out_valid", 32'(out_valid), 32'(e_out_valid));
        if (out_valid && out_ready) outq.push_back(out_data);
        if (e_accept) inq.push_back(in_data);
        if (e_accept && acc_cyc < 0) acc_cyc = cyc;
        if (out_valid && out_cyc < 0) out_cyc = cyc;
        if (int'(occupancy) > peak) peak = int'(occupancy);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < N; k++) begin
                mv[k] = nv[k];
                md[k] = nd[k];
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stall    = '0;
        flush    = '0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        repeat (N + 3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] s2;
        int            n0;
        bit            leaked;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = '0; flush = '0;
        cyc = 0; acc_cyc = -1; out_cyc = -1; peak = 0;
        model_clear();
        #3;
        reset_checks();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 1);

        // Streaming 0x1..0x8
        out_ready = 1'b1;
        in_valid  = 1'b1;
        outq.delete();
        acc_cyc = -1; out_cyc = -1; peak = 0;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            tick();
        end
        drain();
        chk("stream_latency", out_cyc - acc_cyc, 5);
        chk("stream_peak_occ", peak, 5);
        chk("stream_count", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            chk($sformatf("stream_item%0d", i), outq[i], 32'(i + 1));
        end

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 32'h100 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_occupancy", 32'(occupancy), 5);
        chk("bp_out_data", out_data, 32'h101);
        n0 = outq.size();
        out_ready = 1'b1;
        #1;
        chk("bp_ready_on_accept", 32'(in_ready), 1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_one_left", outq.size() - n0, 1);
        chk("bp_occ_after", 32'(occupancy), 4);
        drain();

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h201;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("bubble_first", 32'(stg_valid), 32'b10000);
        in_valid = 1'b1;
        in_data  = 32'h202;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1;
        chk("bubble_second", 32'(stg_valid), 32'b11000);
        chk("bubble_occ", 32'(occupancy), 2);
        drain();

        // Stall of stage 2 on a full, advancing pipe
        inq.delete();
        outq.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h300 + 32'(i);
            tick();
        end
        s2 = md[2];
        stall[2] = 1'b1;
        for (int i = 5; i < 8; i++) begin
            in_data = 32'h300 + 32'(i);
            tick();
            chk("stall_s2_hold", stg_data[2*DW +: DW], s2);
        end
        #1;
        chk("stall_shape", 32'(stg_valid), 32'b00111);
        stall[2] = 1'b0;
        for (int i = 8; i < 11; i++) begin
            in_data = 32'h300 + 32'(i);
            tick();
        end
        drain();
        chk("stall_count", outq.size(), inq.size());
        for (int i = 0; i < inq.size() && i < outq.size(); i++) begin
            chk($sformatf("stall_item%0d", i), outq[i], inq[i]);
        end

        // Flush versus load
        outq.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = (i < 3) ? 32'h401 + 32'(i) : (i == 3) ? 32'hBB : 32'hCC;
            tick();
        end
        flush   = 5'b00011;
        in_data = 32'hAA;
        #1;
        chk("flush_in_ready", 32'(in_ready), 1);
        tick();
        idle();
        #1;
        chk("flush_v01", 32'(stg_valid[1:0]), 0);
        chk("flush_occ", 32'(occupancy), 3);
        drain();
        chk("flush_count", outq.size(), 3);
        leaked = 1'b0;
        for (int i = 0; i < outq.size(); i++) begin
            if (outq[i] == 32'hAA || outq[i] == 32'hBB || outq[i] == 32'hCC) leaked = 1'b1;
        end
        chk("flush_no_leak", 32'(leaked), 0);
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            chk($sformatf("flush_item%0d", i), outq[i], 32'h401 + 32'(i));
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h500 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        reset_checks();
        model_clear();
        @(negedge clk);
        tick();
        rst = 1'b0;
        outq.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h510 + 32'(i);
            tick();
        end
        drain();
        chk("restart_count", outq.size(), 3);
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            chk($sformatf("restart_item%0d", i), outq[i], 32'h510 + 32'(i));
        end

        // Random traffic with stalls and flushes
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                stall[k] = ($urandom_range(0, 7) == 0);
                flush[k] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
